// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: machine word, fetch FSM states,
// next-PC select codes, fetch slot payload and reset defaults.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_STEP,
    SEL_TARGET
  } pc_sel_e;

  // Fetch slot payload handed to decode.
  typedef struct packed {
    word_t ins;
    word_t pc;
  } slot_t;

  localparam word_t DEF_RESET_PC = 32'h0000_0000;
  localparam word_t DEF_PC_STEP  = 32'h0000_0001;

endpackage

// File: rtl/pc_next.sv
// Next fetch PC selection: hold, sequential step (wraps mod 2^32) or redirect.
// Ports:
//   pc        current fetch PC
//   target    redirect PC
//   sel       selection code
//   next_pc_c combinational next PC
module pc_next
  import cpu_pkg::*;
#(
  parameter word_t PC_STEP = DEF_PC_STEP
) (
  input  word_t   pc,
  input  word_t   target,
  input  pc_sel_e sel,
  output word_t   next_pc_c
);

  always_comb begin
    next_pc_c = pc;
    case (sel)
      SEL_STEP:   next_pc_c = pc + PC_STEP;
      SEL_TARGET: next_pc_c = target;
      default:    next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: drives a combinational instruction memory
// through fPC and holds one fetched instruction in a slot for decode.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fPC, ins          memory address out, instruction in (same cycle)
//   if_valid/ins/pc   fetch slot to decode; if_ready accepts it
//   br_taken/target   one-cycle redirect from execute
//   halt, halted      stop request (level) and halted status
//   fetch_cnt         saturating count of slot transfers
module fetch_seq
  import cpu_pkg::*;
#(
  parameter word_t       RESET_PC = DEF_RESET_PC,
  parameter word_t       PC_STEP  = DEF_PC_STEP,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output word_t            fPC,
  input  word_t            ins,
  output logic             if_valid,
  output word_t            if_ins,
  output word_t            if_pc,
  input  logic             if_ready,
  input  logic             br_taken,
  input  word_t            br_target,
  input  logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  state_e  state;
  state_e  state_next;
  pc_sel_e pc_sel;
  word_t   pc_nxt;
  slot_t   slot;
  logic    load;
  logic    flush;
  logic    transfer;

  assign transfer = if_valid & if_ready;
  assign if_ins   = slot.ins;
  assign if_pc    = slot.pc;

  pc_next #(
    .PC_STEP (PC_STEP)
  ) u_pc_next (
    .pc        (fPC),
    .target    (br_target),
    .sel       (pc_sel),
    .next_pc_c (pc_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_next;
  end

  // Next state and fetch control; halt has priority over a redirect.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    flush      = 1'b0;
    pc_sel     = SEL_HOLD;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_next = ST_HALTED;
        end else if (br_taken) begin
          flush  = 1'b1;
          pc_sel = SEL_TARGET;
        end else if (!if_valid || if_ready) begin
          load   = 1'b1;
          pc_sel = SEL_STEP;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_BOOT;
    endcase
  end

  // Fetch PC, slot, halted flag and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      fPC       <= RESET_PC;
      if_valid  <= 1'b0;
      slot      <= '0;
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      fPC    <= pc_nxt;
      halted <= (state_next == ST_HALTED);
      if (load) begin
        if_valid <= 1'b1;
        slot     <= '{ins: ins, pc: fPC};
      end else if (flush || transfer) begin
        if_valid <= 1'b0;
      end
      if (transfer && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a transfer scoreboard: expected slot
// contents are queued as stimulus enables transfers and a negedge monitor
// pops and compares on every if_valid & if_ready.
module tb_fetch_seq;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic [31:0] mem [16];
  exp_t        q0[$];
  exp_t        q1[$];
  int          n_chk = 0;
  int          n_pass = 0;

  // Default-parameter instance.
  logic        rst, rdy0, br0, halt0;
  logic [31:0] tgt0, ins0, fpc0, iins0, ipc0;
  logic        v0, hd0;
  logic [15:0] cnt0;

  // Wrap / saturation instance.
  logic        rst1, rdy1, br1, halt1;
  logic [31:0] tgt1, ins1, fpc1, iins1, ipc1;
  logic        v1, hd1;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  assign ins0 = mem[fpc0[3:0]];
  assign ins1 = mem[fpc1[3:0]];

  fetch_seq u0 (
    .clk(clk), .rst(rst), .fPC(fpc0), .ins(ins0),
    .if_valid(v0), .if_ins(iins0), .if_pc(ipc0), .if_ready(rdy0),
    .br_taken(br0), .br_target(tgt0), .halt(halt0), .halted(hd0),
    .fetch_cnt(cnt0)
  );

  fetch_seq #(.RESET_PC(32'hFFFF_FFFF), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst1), .fPC(fpc1), .ins(ins1),
    .if_valid(v1), .if_ins(iins1), .if_pc(ipc1), .if_ready(rdy1),
    .br_taken(br1), .br_target(tgt1), .halt(halt1), .halted(hd1),
    .fetch_cnt(cnt1)
  );

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] a);
    q0.push_back('{pc: a, ins: mem[a[3:0]]});
  endtask

  task automatic push1(input logic [31:0] a);
    q1.push_back('{pc: a, ins: mem[a[3:0]]});
  endtask

  // Scoreboard monitor: a transfer happens at the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && v0 && rdy0) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL xfer0_unexpected: got pc %h expected no transfer", ipc0);
      end else begin
        e = q0.pop_front();
        chk("xfer0_pc", ipc0, e.pc);
        chk("xfer0_ins", iins0, e.ins);
      end
    end
    if (!rst1 && v1 && rdy1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL xfer1_unexpected: got pc %h expected no transfer", ipc1);
      end else begin
        e = q1.pop_front();
        chk("xfer1_pc", ipc1, e.pc);
        chk("xfer1_ins", iins1, e.ins);
      end
    end
  end

  initial begin
    mem[0] = 32'h00222020; mem[1] = 32'h00222021;
    mem[2] = 32'h00222022; mem[3] = 32'h00222024;
    mem[4] = 32'h00222025; mem[5] = 32'h00222026;
    mem[6] = 32'h00222027; mem[7] = 32'h10222000;
    for (int i = 8; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);

    rst = 1'b1; rdy0 = 1'b0; br0 = 1'b0; halt0 = 1'b0; tgt0 = '0;
    rst1 = 1'b1; rdy1 = 1'b0; br1 = 1'b0; halt1 = 1'b0; tgt1 = '0;
    step(); step();
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_fpc", fpc0, 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_halted", 32'(hd0), 32'd0);
    chk("rst_if_ins", iins0, 32'd0);
    chk("rst_if_pc", ipc0, 32'd0);

    // Streaming
    rst = 1'b0; rdy0 = 1'b1;
    for (int a = 0; a < 4; a++) push0(32'(a));
    step();
    chk("boot_valid", 32'(v0), 32'd0);
    chk("boot_fpc", fpc0, 32'd0);
    step();
    chk("s0_pc", ipc0, 32'd0);
    chk("s0_ins", iins0, 32'h00222020);
    step();
    chk("s1_pc", ipc0, 32'd1);
    step();
    chk("s2_pc", ipc0, 32'd2);
    chk("s2_ins", iins0, 32'h00222022);
    step();
    chk("s3_pc", ipc0, 32'd3);
    chk("s3_cnt", 32'(cnt0), 32'd3);

    // Backpressure
    rdy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_pc", ipc0, 32'd3);
      chk("bp_ins", iins0, 32'h00222024);
      chk("bp_fpc", fpc0, 32'd4);
      chk("bp_cnt", 32'(cnt0), 32'd3);
    end
    rdy0 = 1'b1;
    step();
    chk("rel_pc", ipc0, 32'd4);
    chk("rel_cnt", 32'(cnt0), 32'd4);

    // Redirect under backpressure
    rdy0 = 1'b0; br0 = 1'b1; tgt0 = 32'd7;
    step();
    chk("br_valid", 32'(v0), 32'd0);
    chk("br_fpc", fpc0, 32'd7);
    br0 = 1'b0;
    step();
    chk("br_restart_valid", 32'(v0), 32'd1);
    chk("br_restart_pc", ipc0, 32'd7);
    chk("br_restart_ins", iins0, 32'h10222000);
    chk("br_restart_fpc", fpc0, 32'd8);

    // Transfer coincident with redirect still counts
    push0(32'd7);
    rdy0 = 1'b1; br0 = 1'b1; tgt0 = 32'd4;
    step();
    chk("brx_valid", 32'(v0), 32'd0);
    chk("brx_fpc", fpc0, 32'd4);
    chk("brx_cnt", 32'(cnt0), 32'd5);
    br0 = 1'b0; rdy0 = 1'b0;
    step();
    chk("brx_load_pc", ipc0, 32'd4);
    chk("brx_load_fpc", fpc0, 32'd5);

    // Halt together with redirect: halt wins
    halt0 = 1'b1; br0 = 1'b1; tgt0 = 32'd9;
    step();
    chk("halt_halted", 32'(hd0), 32'd1);
    chk("halt_fpc", fpc0, 32'd5);
    chk("halt_slot_valid", 32'(v0), 32'd1);
    chk("halt_slot_pc", ipc0, 32'd4);
    halt0 = 1'b0; br0 = 1'b0;
    push0(32'd4);
    rdy0 = 1'b1;
    step();
    chk("drain_valid", 32'(v0), 32'd0);
    chk("drain_cnt", 32'(cnt0), 32'd6);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halted_valid", 32'(v0), 32'd0);
      chk("halted_fpc", fpc0, 32'd5);
      chk("halted_flag", 32'(hd0), 32'd1);
    end

    // Reset out of HALTED, restream to fPC=6
    rst = 1'b1;
    step();
    chk("rst2_halted", 32'(hd0), 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 5; a++) push0(32'(a));
    step();
    for (int i = 0; i < 6; i++) step();
    chk("mid_fpc", fpc0, 32'd6);
    chk("mid_valid", 32'(v0), 32'd1);
    chk("mid_pc", ipc0, 32'd5);
    chk("mid_cnt", 32'(cnt0), 32'd5);

    // Mid-stream reset
    rst = 1'b1; rdy0 = 1'b0;
    step();
    chk("mrst_valid", 32'(v0), 32'd0);
    chk("mrst_fpc", fpc0, 32'd0);
    chk("mrst_cnt", 32'(cnt0), 32'd0);
    chk("mrst_pc", ipc0, 32'd0);
    chk("mrst_ins", iins0, 32'd0);
    rst = 1'b0;
    step();
    chk("mrst_boot_valid", 32'(v0), 32'd0);
    step();
    chk("mrst_load_valid", 32'(v0), 32'd1);
    chk("mrst_load_pc", ipc0, 32'd0);
    chk("mrst_load_fpc", fpc0, 32'd1);
    push0(32'd0);
    rdy0 = 1'b1;
    step();
    rdy0 = 1'b0;
    chk("mrst_xfer_cnt", 32'(cnt0), 32'd1);

    // Wrap and saturation
    chk("w_rst_fpc", fpc1, 32'hFFFF_FFFF);
    chk("w_rst_cnt", 32'(cnt1), 32'd0);
    rst1 = 1'b0; rdy1 = 1'b1;
    push1(32'hFFFF_FFFF);
    for (int a = 0; a < 4; a++) push1(32'(a));
    step();
    step();
    chk("w_load_pc", ipc1, 32'hFFFF_FFFF);
    chk("w_load_fpc", fpc1, 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("w_cnt3", 32'(cnt1), 32'd3);
    step();
    chk("w_cnt4_sat", 32'(cnt1), 32'd3);
    step();
    rdy1 = 1'b0;
    chk("w_cnt5_sat", 32'(cnt1), 32'd3);

    step();
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first PC fetched after reset.
REQ-002 Parameter PC_STEP, default 1, is the sequential PC increment; the instruction memory is word-indexed.
REQ-003 Parameter CNT_W, default 16, is the width of the retired-fetch counter.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 fPC  out  32  fetch address driven to the combinational instruction memory.
REQ-007 ins  in  32  instruction returned by memory for the current fPC, same cycle.
REQ-008 if_valid  out  1  fetch slot holds an instruction for decode.
REQ-009 if_ins  out  32  slot instruction.
REQ-010 if_pc  out  32  PC of the slot instruction.
REQ-011 if_ready  in  1  decode accepts the slot this cycle.
REQ-012 br_taken  in  1  redirect request from execute, one-cycle pulse.
REQ-013 br_target  in  32  redirect PC, sampled when br_taken=1.
REQ-014 halt  in  1  stop fetching; level-sensitive, sampled each cycle.
REQ-015 halted  out  1  high while in HALTED.
REQ-016 fetch_cnt  out  CNT_W  count of transfers accepted by decode.

Function
REQ-017 States: BOOT, RUN, HALTED; the state register is internal.
- BOOT: one cycle after reset, then RUN.
- RUN: RUN to HALTED when halt=1.
- HALTED: exits only on rst.
REQ-018 Transfer condition: transfer = if_valid & if_ready.
REQ-019 Load condition: in RUN, load = (!if_valid | if_ready) & !br_taken & !halt.
- On load, the slot captures {ins, fPC} and if_valid becomes 1.
- On load, fPC advances to fPC+PC_STEP.
REQ-020 Latency: the instruction at address A appears on if_ins with if_pc=A exactly one cycle after fPC=A is presented with load=1.
REQ-021 Sustained rate: with if_ready held at 1, exactly one instruction is delivered per cycle with no bubbles.
REQ-022 Backpressure: when if_valid=1 and if_ready=0, the slot and fPC hold; if_ins and if_pc stay stable until transfer.
REQ-023 Redirect: when br_taken=1 in RUN, the next cycle has fPC=br_target and if_valid=0.
- The slot is flushed even if if_ready=0.
- A transfer coincident with br_taken still counts.
REQ-024 Redirect restart: the first instruction from br_target is valid two cycles after the br_taken cycle.
REQ-025 Halt: on halt=1, no further loads occur and fPC holds.
- A valid slot remains until transferred, then if_valid=0.
- halted=1 from the cycle after halt is sampled.
REQ-026 Simultaneous halt and br_taken: halt wins; br_target is ignored and fPC holds.
REQ-027 fPC+PC_STEP wraps modulo 2^32 with no flag.
REQ-028 fetch_cnt increments on each transfer and saturates at all-ones.
REQ-029 Inputs are ignored in BOOT: no load, no redirect; fPC=RESET_PC.

Reset
REQ-030 With rst=1 at a clock edge, the following take effect at that edge:
- state=BOOT; fPC=RESET_PC.
- if_valid=0; if_ins=0; if_pc=0.
- halted=0; fetch_cnt=0.
REQ-031 Reset overrides all other inputs in the same cycle, including in-flight backpressure, redirect and halt.
REQ-032 After rst deasserts: one BOOT cycle, and the first load occurs in the following cycle.

Structure
REQ-033 A shared package cpu_pkg holds:
- the state enum (BOOT, RUN, HALTED);
- the default RESET_PC and PC_STEP;
- the 32-bit word typedef used by the instruction memory and this block.
REQ-034 Next-PC selection (hold / step / br_target) is a combinational sub-module named pc_next; everything else lives in fetch_seq.
REQ-035 Instantiation: fetch_seq drives the existing instruction memory via fPC and reads ins; no other memory port is added.

Verification
REQ-036 The bench shall cover the following directed scenarios:
- Streaming: rst 2 cycles, if_ready=1 -> if_pc = 0,1,2,3 on consecutive cycles; if_ins at pc 0 = 32'h00222020, at pc 2 = 32'h00222022; fetch_cnt=4 after 4 transfers.
- Backpressure: if_ready=0 for 3 cycles at if_pc=3 -> if_ins=32'h00222024 held, fPC=4 held, fetch_cnt unchanged; release -> if_pc=4 next cycle.
- Redirect: br_taken with br_target=7 while if_ready=0 -> next cycle if_valid=0, fPC=7; following cycle if_pc=7, if_ins=32'h10222000.
- Halt vs branch: halt=1 and br_taken=1 (target 9) at fPC=5 with a valid slot -> fPC stays 5, slot drains on if_ready, halted=1, no further if_valid.
- Mid-stream reset: rst pulsed at fPC=6 with if_valid=1 -> next cycle if_valid=0, fPC=0, fetch_cnt=0; the first load after the BOOT cycle.
- Wrap and saturation: RESET_PC=32'hFFFF_FFFF, CNT_W=2 -> fPC=0 after the first load; fetch_cnt stops at 3 after 5 transfers.
